// File: rtl/system_0_sysid_reader_pkg.sv
// Shared types and constants for the system_0 sysid reader.
package system_0_sysid_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_TS_REQ,
    ST_TS_WAIT,
    ST_DONE
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  localparam int   TMO_WIDTH     = 8;

endpackage

// File: rtl/system_0_sysid_reader_timeout.sv
// Per-read cycle counter; expired is high during the LIMIT-th counted cycle.
module system_0_sysid_reader_timeout
  import system_0_sysid_reader_pkg::*;
#(
  parameter logic [TMO_WIDTH-1:0] LIMIT = 8'd255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of cycles already spent, so LIMIT-1 marks the last allowed cycle
  assign expired = enable && (count == LIMIT - 1'b1);

endmodule

// File: rtl/system_0_sysid_reader.sv
// Avalon-MM master that reads the sysid ID and timestamp words and checks them
// against build-time expected values, with a per-read timeout.
module system_0_sysid_reader
  import system_0_sysid_reader_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1740511524,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter bit          USE_READDATAVALID  = 1'b0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err
);

  state_t state;
  logic   auto_pend;
  logic   in_req, in_wait, in_id;
  logic   accept, capture;
  logic   tmo_en, tmo_clear, tmo_hit;

  always_comb begin
    in_req    = (state == ST_ID_REQ) || (state == ST_TS_REQ);
    in_wait   = (state == ST_ID_WAIT) || (state == ST_TS_WAIT);
    in_id     = (state == ST_ID_REQ) || (state == ST_ID_WAIT);
    accept    = in_req && !avm_waitrequest;
    capture   = USE_READDATAVALID ? (in_wait && avm_readdatavalid) : accept;
    tmo_en    = in_req || in_wait;
    tmo_clear = !tmo_en || (in_id && capture);
  end

  system_0_sysid_reader_timeout #(
    .LIMIT(TMO_WIDTH'(TIMEOUT_CYCLES))
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (tmo_clear),
    .enable (tmo_en),
    .expired(tmo_hit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      auto_pend       <= AUTO_START;
      avm_read        <= 1'b0;
      avm_address     <= SYSID_ADDR_ID;
      id_value        <= '0;
      timestamp_value <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start || (state == ST_IDLE && auto_pend)) begin
            state           <= ST_ID_REQ;
            auto_pend       <= 1'b0;
            avm_read        <= 1'b1;
            avm_address     <= SYSID_ADDR_ID;
            id_value        <= '0;
            timestamp_value <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            id_ok           <= 1'b0;
            ts_ok           <= 1'b0;
            timeout_err     <= 1'b0;
          end
        end
        ST_ID_REQ, ST_ID_WAIT, ST_TS_REQ, ST_TS_WAIT: begin
          if (capture) begin
            if (in_id) begin
              id_value    <= avm_readdata;
              state       <= ST_TS_REQ;
              avm_read    <= 1'b1;
              avm_address <= SYSID_ADDR_TS;
            end else begin
              timestamp_value <= avm_readdata;
              state           <= ST_DONE;
              avm_read        <= 1'b0;
              avm_address     <= SYSID_ADDR_ID;
              busy            <= 1'b0;
              done            <= 1'b1;
              id_ok           <= (id_value == EXPECTED_ID);
              ts_ok           <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
          end else if (tmo_hit) begin
            // an accepted-but-unanswered pipelined read also times out; its late reply is dropped
            state       <= ST_DONE;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
            id_ok       <= !in_id && (id_value == EXPECTED_ID);
            ts_ok       <= 1'b0;
          end else if (accept && USE_READDATAVALID) begin
            state    <= in_id ? ST_ID_WAIT : ST_TS_WAIT;
            avm_read <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
